// File: rtl/gfp_to_fp_pipe_pkg.sv
// gfp_conv_pkg: shared types and helpers for the GFP-to-float converter.
// Holds the rounding-mode enum, standard float field widths and the helpers
// that derive exponent bias and packed result width from the field widths.
package gfp_conv_pkg;

   typedef enum logic {
      RNE = 1'b0,   // round to nearest, ties to even
      RTZ = 1'b1    // round toward zero (truncate)
   } round_mode_e;

   localparam int FP16_EXP_W = 5;
   localparam int FP16_MAN_W = 10;
   localparam int BF16_EXP_W = 8;
   localparam int BF16_MAN_W = 7;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;

   // Exponent bias for an IEEE-style exponent field of exp_w bits.
   function automatic int fp_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Packed {sign, exp, frac} width of one converted lane.
   function automatic int fp_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

endpackage

// File: rtl/gfp_to_fp_pipe_if.sv
// gfp_to_fp_pipe_if: beat-level bus of the GFP-to-float converter.
// Handshake: a beat moves on a side whenever that side's valid and ready are
// both high on a rising clock edge; a producer holding valid high keeps its
// payload stable until the transfer happens.
// Status signals exist only when GFP_CONV_STATUS_EN is defined.
interface gfp_to_fp_pipe_if #(
   parameter int NUM_LANES = 4,
   parameter int MANT_W    = 32,
   parameter int EXP_IN_W  = 8,
   parameter int OUT_W     = 16
);
   logic                          i_valid;
   logic                          o_ready;
   logic [NUM_LANES*MANT_W-1:0]   i_mantissa;
   logic [NUM_LANES*EXP_IN_W-1:0] i_exponent;
   logic                          i_round_mode;
   logic                          o_valid;
   logic                          i_ready;
   logic [NUM_LANES*OUT_W-1:0]    o_result;
`ifdef GFP_CONV_STATUS_EN
   logic [NUM_LANES*3-1:0]        o_status;
   logic [2:0]                    o_status_sticky;
   logic                          i_status_clr;

   modport master (
      output i_valid, i_mantissa, i_exponent, i_round_mode, i_ready, i_status_clr,
      input  o_ready, o_valid, o_result, o_status, o_status_sticky
   );
   modport slave (
      input  i_valid, i_mantissa, i_exponent, i_round_mode, i_ready, i_status_clr,
      output o_ready, o_valid, o_result, o_status, o_status_sticky
   );
`else
   modport master (
      output i_valid, i_mantissa, i_exponent, i_round_mode, i_ready,
      input  o_ready, o_valid, o_result
   );
   modport slave (
      input  i_valid, i_mantissa, i_exponent, i_round_mode, i_ready,
      output o_ready, o_valid, o_result
   );
`endif
endinterface

// File: rtl/gfp_to_fp_pipe_lzc.sv
// gfp_lzc: combinational leading-zero counter. An all-zero input gives WIDTH.
module gfp_lzc #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]       data_i,
   output logic [$clog2(WIDTH):0] count_o
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      count_o = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
      end
   end
endmodule

// File: rtl/gfp_to_fp_pipe.sv
// gfp_to_fp_pipe: converts NUM_LANES GFP values (signed mantissa, unbiased
// signed exponent) into {sign, exp, frac} floats, two registered stages with
// valid/ready backpressure. Stage 1 normalises, stage 2 rounds and packs.
// Define GFP_CONV_STATUS_EN to add per-lane and sticky status outputs.
module gfp_to_fp_pipe
   import gfp_conv_pkg::*;
#(
   parameter int NUM_LANES = 4,
   parameter int MANT_W    = 32,
   parameter int EXP_IN_W  = 8,
   parameter int OUT_EXP_W = 5,
   parameter int OUT_MAN_W = 10,
   parameter int SATURATE  = 0
) (
   input logic             i_clk,
   input logic             i_reset_n,
   gfp_to_fp_pipe_if.slave bus
);
   localparam int OUT_W   = fp_width(OUT_EXP_W, OUT_MAN_W);
   localparam int FIELD_W = OUT_EXP_W + OUT_MAN_W;
   localparam int BIAS    = fp_bias(OUT_EXP_W);
   localparam int LZ_W    = $clog2(MANT_W) + 1;
   localparam int E_W     = EXP_IN_W + $clog2(MANT_W) + 3;
   localparam int EXP_MAX = (1 << OUT_EXP_W) - 1;
   localparam int SH_CAP  = OUT_MAN_W + 2;

   // Stage 1 registers
   logic                       s1_valid_q;
   round_mode_e                s1_rm_q;
   logic [NUM_LANES-1:0]       s1_sign_q, s1_zero_q;
   logic [MANT_W-1:0]          s1_norm_q [NUM_LANES];
   logic [LZ_W-1:0]            s1_lz_q   [NUM_LANES];
   logic signed [EXP_IN_W-1:0] s1_exp_q  [NUM_LANES];
   // Stage 2 registers
   logic                       s2_valid_q;
   logic [NUM_LANES*OUT_W-1:0] s2_res_q;
   // Next-state values
   logic [NUM_LANES-1:0]       sign_d, zero_d;
   logic [MANT_W-1:0]          abs_w     [NUM_LANES];
   logic [MANT_W-1:0]          norm_d    [NUM_LANES];
   logic [LZ_W-1:0]            lz_d      [NUM_LANES];
   logic [NUM_LANES*OUT_W-1:0] res_d;
   logic                       s1_adv, s2_adv;
`ifdef GFP_CONV_STATUS_EN
   logic [NUM_LANES*3-1:0]     stat_d, s2_stat_q;
   logic [2:0]                 sticky_q, beat_or_w;
`endif

   // A stage may load when it is empty or its contents move on this edge.
   assign s2_adv      = !s2_valid_q || bus.i_ready;
   assign s1_adv      = !s1_valid_q || s2_adv;
   assign bus.o_ready = s1_adv;
   assign bus.o_valid = s2_valid_q;
   assign bus.o_result = s2_res_q;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic signed [E_W-1:0]   e_w;
      logic [E_W-1:0]          sh_w;
      logic [MANT_W-2:0]       shifted_w;
      logic [OUT_MAN_W-1:0]    frac_w;
      logic [OUT_EXP_W-1:0]    efield_w;
      logic [FIELD_W-1:0]      sum_w;
      logic                    lost_w, guard_w, sticky_w, inc_w, ovf_w;
      logic [OUT_W-1:0]        res_w;

      // Stage 1: sign, exact magnitude (most-negative input stays exact), normalisation.
      assign sign_d[g] = bus.i_mantissa[g*MANT_W + MANT_W - 1];
      assign abs_w[g]  = sign_d[g] ? (~bus.i_mantissa[g*MANT_W +: MANT_W] + MANT_W'(1))
                                   : bus.i_mantissa[g*MANT_W +: MANT_W];
      assign zero_d[g] = (abs_w[g] == '0);
      gfp_lzc #(.WIDTH(MANT_W)) u_lzc (.data_i(abs_w[g]), .count_o(lz_d[g]));
      assign norm_d[g] = abs_w[g] << lz_d[g];

      // Stage 2: bias the exponent, denormalise if needed, round, detect overflow, pack.
      always_comb begin
         e_w       = E_W'(s1_exp_q[g]) + E_W'(MANT_W - 1 + BIAS) - E_W'(s1_lz_q[g]);
         sh_w      = '0;
         shifted_w = s1_norm_q[g][MANT_W-2:0];
         lost_w    = 1'b0;
         efield_w  = e_w[OUT_EXP_W-1:0];
         if (e_w < 1) begin
            sh_w = E_W'(1 - e_w);
            if (sh_w > E_W'(SH_CAP)) sh_w = E_W'(SH_CAP);
            shifted_w = (MANT_W-1)'(s1_norm_q[g] >> sh_w);
            lost_w    = |(s1_norm_q[g] & ~({MANT_W{1'b1}} << sh_w));
            efield_w  = '0;
         end
         frac_w   = shifted_w[MANT_W-2 -: OUT_MAN_W];
         guard_w  = shifted_w[MANT_W-2-OUT_MAN_W];
         sticky_w = lost_w | (|shifted_w[MANT_W-3-OUT_MAN_W:0]);
         inc_w    = (s1_rm_q == RNE) && guard_w && (sticky_w || frac_w[0]);
         // A fraction carry ripples into the exponent field naturally.
         sum_w    = {efield_w, frac_w} + FIELD_W'(inc_w);
         ovf_w    = (e_w >= EXP_MAX) || (sum_w[FIELD_W-1 -: OUT_EXP_W] == {OUT_EXP_W{1'b1}});
         if (s1_zero_q[g])
            res_w = '0;
         else if (ovf_w && (SATURATE != 0 || s1_rm_q == RTZ))
            res_w = {s1_sign_q[g], OUT_EXP_W'(EXP_MAX - 1), {OUT_MAN_W{1'b1}}};
         else if (ovf_w)
            res_w = {s1_sign_q[g], {OUT_EXP_W{1'b1}}, {OUT_MAN_W{1'b0}}};
         else
            res_w = {s1_sign_q[g], sum_w};
      end
      assign res_d[g*OUT_W +: OUT_W] = res_w;
`ifdef GFP_CONV_STATUS_EN
      // {overflow, underflow to zero/denormal, inexact}; an exact zero input flags nothing.
      assign stat_d[g*3 +: 3] = {
         !s1_zero_q[g] && ovf_w,
         !s1_zero_q[g] && !ovf_w && (sum_w[FIELD_W-1 -: OUT_EXP_W] == '0),
         !s1_zero_q[g] && (guard_w || sticky_w || ovf_w)};
`endif
   end

   // Stage 1 register: capture the normalised beat when it can advance.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s1_valid_q <= 1'b0;
         s1_rm_q    <= RNE;
         s1_sign_q  <= '0;
         s1_zero_q  <= '0;
         for (int k = 0; k < NUM_LANES; k++) begin
            s1_norm_q[k] <= '0;
            s1_lz_q[k]   <= '0;
            s1_exp_q[k]  <= '0;
         end
      end else if (s1_adv) begin
         s1_valid_q <= bus.i_valid;
         if (bus.i_valid) begin
            s1_rm_q   <= round_mode_e'(bus.i_round_mode);
            s1_sign_q <= sign_d;
            s1_zero_q <= zero_d;
            for (int k = 0; k < NUM_LANES; k++) begin
               s1_norm_q[k] <= norm_d[k];
               s1_lz_q[k]   <= lz_d[k];
               s1_exp_q[k]  <= bus.i_exponent[k*EXP_IN_W +: EXP_IN_W];
            end
         end
      end
   end

   // Stage 2 register: output beat, held unchanged while downstream stalls.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
`ifdef GFP_CONV_STATUS_EN
         s2_stat_q  <= '0;
`endif
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_res_q  <= res_d;
`ifdef GFP_CONV_STATUS_EN
            s2_stat_q <= stat_d;
`endif
         end
      end
   end

`ifdef GFP_CONV_STATUS_EN
   // OR the per-lane flags of the current output beat.
   always_comb begin
      beat_or_w = '0;
      for (int k = 0; k < NUM_LANES; k++) beat_or_w = beat_or_w | s2_stat_q[k*3 +: 3];
   end

   // Sticky status accumulates transferred beats; a clear overrides a same-cycle set.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)                        sticky_q <= '0;
      else if (bus.i_status_clr)             sticky_q <= '0;
      else if (s2_valid_q && bus.i_ready)    sticky_q <= sticky_q | beat_or_w;
   end

   assign bus.o_status        = s2_stat_q;
   assign bus.o_status_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_gfp_to_fp_pipe.sv
// tb_gfp_to_fp_pipe: directed bench for gfp_to_fp_pipe. Three instances share
// one stimulus: FP16, FP16 with saturation, and BF16. Covers exact values,
// rounding, denormals, overflow, backpressure, reset, and (with
// GFP_CONV_STATUS_EN) the status outputs.
module tb_gfp_to_fp_pipe;
   import gfp_conv_pkg::*;

   localparam int NL = 4;
   localparam int MW = 32;
   localparam int EW = 8;
   localparam int OW = 16;

   typedef struct {
      logic [MW-1:0] mant;
      logic [EW-1:0] expo;
      logic          rm;
      logic [OW-1:0] r16;
      logic [OW-1:0] rsat;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic              valid, rm, rdy, clr;
   logic [NL*MW-1:0]  mant;
   logic [NL*EW-1:0]  expo;

   gfp_to_fp_pipe_if #(.NUM_LANES(NL), .MANT_W(MW), .EXP_IN_W(EW), .OUT_W(OW)) bus16 ();
   gfp_to_fp_pipe_if #(.NUM_LANES(NL), .MANT_W(MW), .EXP_IN_W(EW), .OUT_W(OW)) bus_sat ();
   gfp_to_fp_pipe_if #(.NUM_LANES(NL), .MANT_W(MW), .EXP_IN_W(EW), .OUT_W(OW)) bus_bf ();

   assign bus16.i_valid   = valid;  assign bus_sat.i_valid   = valid;  assign bus_bf.i_valid   = valid;
   assign bus16.i_ready   = rdy;    assign bus_sat.i_ready   = rdy;    assign bus_bf.i_ready   = rdy;
   assign bus16.i_round_mode = rm;  assign bus_sat.i_round_mode = rm;  assign bus_bf.i_round_mode = rm;
   assign bus16.i_mantissa = mant;  assign bus_sat.i_mantissa = mant;  assign bus_bf.i_mantissa = mant;
   assign bus16.i_exponent = expo;  assign bus_sat.i_exponent = expo;  assign bus_bf.i_exponent = expo;
`ifdef GFP_CONV_STATUS_EN
   assign bus16.i_status_clr = clr; assign bus_sat.i_status_clr = clr; assign bus_bf.i_status_clr = clr;
`endif

   gfp_to_fp_pipe #(.NUM_LANES(NL), .MANT_W(MW), .EXP_IN_W(EW), .OUT_EXP_W(5), .OUT_MAN_W(10),
                    .SATURATE(0)) u_fp16 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus16));
   gfp_to_fp_pipe #(.NUM_LANES(NL), .MANT_W(MW), .EXP_IN_W(EW), .OUT_EXP_W(5), .OUT_MAN_W(10),
                    .SATURATE(1)) u_sat (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_sat));
   gfp_to_fp_pipe #(.NUM_LANES(NL), .MANT_W(MW), .EXP_IN_W(EW), .OUT_EXP_W(8), .OUT_MAN_W(7),
                    .SATURATE(0)) u_bf16 (.i_clk(clk), .i_reset_n(rst_n), .bus(bus_bf));

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [NL*OW-1:0] exp_q[$];
   vec_t tv [20];
   logic [OW-1:0] bf_exp [NL];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic vec_t mk(input logic [MW-1:0] m, input int e, input logic r,
                               input logic [OW-1:0] r16, input logic [OW-1:0] rsat);
      vec_t v;
      v.mant = m;  v.expo = EW'(e);  v.rm = r;  v.r16 = r16;  v.rsat = rsat;
      return v;
   endfunction

   // Stream beat k: every lane is 1 * 2^(k+l-3), an exact power of two.
   function automatic logic [NL*OW-1:0] stream_exp(input int k);
      logic [NL*OW-1:0] r;
      r = '0;
      for (int l = 0; l < NL; l++) r[l*OW +: OW] = OW'((15 + k + l - 3) << 10);
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   // Send table beat b on an idle pipeline and check latency and all lanes.
   task automatic send_and_check(input int b);
      for (int l = 0; l < NL; l++) begin
         mant[l*MW +: MW] = tv[NL*b+l].mant;
         expo[l*EW +: EW] = tv[NL*b+l].expo;
      end
      rm    = tv[NL*b].rm;   // all lanes of one beat share a rounding mode
      valid = 1'b1;
      #2;
      check($sformatf("accept_ready_b%0d", b), 64'(bus16.o_ready), 64'd1);
      @(posedge clk); @(negedge clk);
      valid = 1'b0;
      check($sformatf("latency_early_b%0d", b), 64'(bus16.o_valid), 64'd0);
      @(posedge clk); @(negedge clk);
      check($sformatf("latency_valid_b%0d", b), 64'(bus16.o_valid), 64'd1);
      for (int l = 0; l < NL; l++) begin
         check($sformatf("fp16_b%0d_l%0d", b, l), 64'(bus16.o_result[l*OW +: OW]), 64'(tv[NL*b+l].r16));
         check($sformatf("sat_b%0d_l%0d", b, l), 64'(bus_sat.o_result[l*OW +: OW]), 64'(tv[NL*b+l].rsat));
      end
      if (b == 0) begin
         for (int l = 0; l < NL; l++)
            check($sformatf("bf16_l%0d", l), 64'(bus_bf.o_result[l*OW +: OW]), 64'(bf_exp[l]));
      end
      @(posedge clk); @(negedge clk);
      check($sformatf("drained_b%0d", b), 64'(bus16.o_valid), 64'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      int sent, got;
      logic acc;
      valid = 1'b0; rm = 1'b0; rdy = 1'b1; clr = 1'b0; mant = '0; expo = '0;

      // beat 0: exact values
      tv[0]  = mk(32'd1, 0, 1'b0, 16'h3C00, 16'h3C00);
      tv[1]  = mk(-3, -1, 1'b0, 16'hBE00, 16'hBE00);
      tv[2]  = mk(32'd0, 0, 1'b0, 16'h0000, 16'h0000);
      tv[3]  = mk(32'h8000_0000, -31, 1'b0, 16'hBC00, 16'hBC00);
      // beat 1: RNE rounding and smallest denormal
      tv[4]  = mk(32'd2049, -11, 1'b0, 16'h3C00, 16'h3C00);
      tv[5]  = mk(32'd2051, -11, 1'b0, 16'h3C02, 16'h3C02);
      tv[6]  = mk(32'd4095, -11, 1'b0, 16'h4000, 16'h4000);
      tv[7]  = mk(32'd1, -24, 1'b0, 16'h0001, 16'h0001);
      // beat 2: denormal rounding, denormal->normal carry, overflow
      tv[8]  = mk(32'd1, -25, 1'b0, 16'h0000, 16'h0000);
      tv[9]  = mk(32'd3, -26, 1'b0, 16'h0001, 16'h0001);
      tv[10] = mk(32'd2047, -25, 1'b0, 16'h0400, 16'h0400);
      tv[11] = mk(32'd1, 16, 1'b0, 16'h7C00, 16'h7BFF);
      // beat 3: RTZ
      tv[12] = mk(32'd2051, -11, 1'b1, 16'h3C01, 16'h3C01);
      tv[13] = mk(32'd1, 16, 1'b1, 16'h7BFF, 16'h7BFF);
      tv[14] = mk(32'd4095, -11, 1'b1, 16'h3FFF, 16'h3FFF);
      tv[15] = mk(32'd3, -26, 1'b1, 16'h0000, 16'h0000);
      // beat 4: negative overflow, plain normals, rounding up into overflow
      tv[16] = mk(-1, 16, 1'b0, 16'hFC00, 16'hFBFF);
      tv[17] = mk(-5, 2, 1'b0, 16'hCD00, 16'hCD00);
      tv[18] = mk(32'd1, 15, 1'b0, 16'h7800, 16'h7800);
      tv[19] = mk(32'd65535, 0, 1'b0, 16'h7C00, 16'h7BFF);
      // BF16 view of beat 0
      bf_exp[0] = 16'h3F80; bf_exp[1] = 16'hBFC0; bf_exp[2] = 16'h0000; bf_exp[3] = 16'hBF80;

      // reset state
      repeat (3) @(negedge clk);
      check("reset_o_valid", 64'(bus16.o_valid), 64'd0);
      check("reset_o_result", 64'(bus16.o_result), 64'd0);
      check("reset_o_ready", 64'(bus16.o_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // table vectors
      for (int b = 0; b < 5; b++) send_and_check(b);

      // backpressure stream: 8 beats, i_ready low in cycles 3..6
      sent = 0; got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         rdy = !(c >= 3 && c <= 6);
         if (sent < 8) begin
            for (int l = 0; l < NL; l++) begin
               mant[l*MW +: MW] = 32'd1;
               expo[l*EW +: EW] = EW'(sent + l - 3);
            end
            rm = 1'b0; valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
         #2;
         check($sformatf("stream_ready_c%0d", c), 64'(bus16.o_ready), 64'(rdy));
         acc = valid && bus16.o_ready;
         if (bus16.o_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL stream_extra_c%0d: got beat %0h expected none", c, bus16.o_result);
            end else begin
               check($sformatf("stream_data_c%0d", c), 64'(bus16.o_result), 64'(exp_q[0]));
               if (rdy) begin
                  void'(exp_q.pop_front());
                  got++;
               end
            end
         end
         if (acc) begin
            exp_q.push_back(stream_exp(sent));
            sent++;
         end
         @(posedge clk); @(negedge clk);
      end
      check("stream_count", 64'(got), 64'd8);
      check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

      // fill both stages, then reset mid-flight
      rdy = 1'b0;
      for (int l = 0; l < NL; l++) begin
         mant[l*MW +: MW] = 32'd1;
         expo[l*EW +: EW] = EW'(l);
      end
      valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      check("full_o_ready", 64'(bus16.o_ready), 64'd0);
      check("full_o_valid", 64'(bus16.o_valid), 64'd1);
      check("full_held", 64'(bus16.o_result), 64'(stream_exp(3)));
      rst_n = 1'b0;
      #1;
      check("midreset_o_valid", 64'(bus16.o_valid), 64'd0);
      check("midreset_o_ready", 64'(bus16.o_ready), 64'd1);
      check("midreset_o_result", 64'(bus16.o_result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1; rdy = 1'b1;
      @(negedge clk);
      check("post_reset_idle", 64'(bus16.o_valid), 64'd0);
      send_and_check(0);

`ifdef GFP_CONV_STATUS_EN
      // status: overflow on lane 0 only, then clear; clear beats a same-cycle set
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("sticky_cleared", 64'(bus16.o_status_sticky), 64'd0);
      mant = '0; expo = '0;
      mant[MW-1:0] = 32'd1; expo[EW-1:0] = 8'd16; rm = 1'b0;
      valid = 1'b1;
      @(posedge clk); @(negedge clk);
      valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("status_lanes", 64'(bus16.o_status), 64'h005);
      check("sticky_before_xfer", 64'(bus16.o_status_sticky), 64'd0);
      @(posedge clk); @(negedge clk);
      check("sticky_set", 64'(bus16.o_status_sticky), 64'd5);
      clr = 1'b1;
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      check("sticky_clr", 64'(bus16.o_status_sticky), 64'd0);
      valid = 1'b1;
      @(posedge clk); @(negedge clk);
      valid = 1'b0;
      @(posedge clk); @(negedge clk);
      clr = 1'b1;
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      check("clr_wins_over_set", 64'(bus16.o_status_sticky), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
